// File: rtl/counter_host_if.sv
// Command, counter-control and sample-return signals between counter_host
// and its environment (command source plus the 8-bit counter it drives).
interface counter_host_if;
  logic       in_cmd_valid;
  logic       out_cmd_ready;
  logic [1:0] in_cmd_op;
  logic [7:0] in_cmd_data;
  logic       in_err_clr;
  logic [7:0] out_load_value;
  logic       out_load_now;
  logic       out_write_now;
  logic [7:0] in_bus_value;
  logic [7:0] in_bus_ena;
  logic       out_rd_valid;
  logic [7:0] out_rd_data;
  logic       out_timeout;
  logic       out_err;

  // Host side: takes commands and bus, drives counter controls and results.
  modport master (
    input  in_cmd_valid, in_cmd_op, in_cmd_data, in_err_clr,
    input  in_bus_value, in_bus_ena,
    output out_cmd_ready, out_load_value, out_load_now, out_write_now,
    output out_rd_valid, out_rd_data, out_timeout, out_err
  );

  // Environment side: issues commands, models the counter, observes results.
  modport slave (
    output in_cmd_valid, in_cmd_op, in_cmd_data, in_err_clr,
    output in_bus_value, in_bus_ena,
    input  out_cmd_ready, out_load_value, out_load_now, out_write_now,
    input  out_rd_valid, out_rd_data, out_timeout, out_err
  );
endinterface

// File: rtl/counter_host.sv
// Initiator for an 8-bit counter's load / output-enable interface.
// Converts LOAD / READ / BURST commands into load strobes and drive requests,
// captures the driven bus and flags protocol or sequence errors.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | ready high, waiting for a command
// S_LOAD    | load_now held high for LOAD_HOLD cycles
// S_RD_WAIT | write_now high, waiting for one full-enable sample
// S_BURST   | write_now high, capturing N samples, checking +1 steps
module counter_host #(
  parameter int LOAD_HOLD = 2,
  parameter int TIMEOUT   = 4
) (
  input logic             in_clk,
  input logic             in_rst,
  counter_host_if.master  host
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RD_WAIT, S_BURST} state_t;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_BURST = 2'b11;

  localparam logic [3:0] HOLD_INIT = 4'(LOAD_HOLD - 1);
  localparam logic [3:0] WAIT_INIT = 4'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       ready_q, ready_d;
  logic [7:0] load_value_q, load_value_d;
  logic       load_now_q, load_now_d;
  logic       write_now_q, write_now_d;
  logic       rd_valid_q, rd_valid_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       timeout_q, timeout_d;
  logic       err_q, err_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] wait_q, wait_d;
  logic [7:0] left_q, left_d;
  logic       have_prev_q, have_prev_d;
  logic       err_set;

  // Next-state and next-output decode; every output leaves through a register.
  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    load_value_d = load_value_q;
    load_now_d   = load_now_q;
    write_now_d  = write_now_q;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;
    timeout_d    = 1'b0;
    hold_d       = hold_q;
    wait_d       = wait_q;
    left_d       = left_q;
    have_prev_d  = have_prev_q;
    err_set      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (host.in_cmd_valid && ready_q) begin
          case (host.in_cmd_op)
            OP_LOAD: begin
              state_d      = S_LOAD;
              ready_d      = 1'b0;
              load_value_d = host.in_cmd_data;
              load_now_d   = 1'b1;
              hold_d       = HOLD_INIT;
            end
            OP_READ: begin
              state_d     = S_RD_WAIT;
              ready_d     = 1'b0;
              write_now_d = 1'b1;
              wait_d      = WAIT_INIT;
            end
            OP_BURST: begin
              state_d     = S_BURST;
              ready_d     = 1'b0;
              write_now_d = 1'b1;
              wait_d      = WAIT_INIT;
              left_d      = (host.in_cmd_data == 8'd0) ? 8'd1 : host.in_cmd_data;
              have_prev_d = 1'b0;
            end
            default: ;
          endcase
        end
      end

      S_LOAD: begin
        if (hold_q == 4'd0) begin
          state_d    = S_IDLE;
          load_now_d = 1'b0;
          ready_d    = 1'b1;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end

      S_RD_WAIT, S_BURST: begin
        if (host.in_bus_ena == 8'hFF) begin
          rd_data_d  = host.in_bus_value;
          rd_valid_d = 1'b1;
          // Monotonic check only applies between samples of one burst.
          if (state_q == S_BURST && have_prev_q &&
              host.in_bus_value != rd_data_q + 8'd1)
            err_set = 1'b1;
          have_prev_d = 1'b1;
          wait_d      = WAIT_INIT;
          if (state_q == S_RD_WAIT || left_q == 8'd1) begin
            state_d     = S_IDLE;
            write_now_d = 1'b0;
            ready_d     = 1'b1;
          end else begin
            left_d = left_q - 8'd1;
          end
        end else begin
          if (host.in_bus_ena != 8'h00)
            err_set = 1'b1;
          if (wait_q == 4'd0) begin
            state_d     = S_IDLE;
            write_now_d = 1'b0;
            ready_d     = 1'b1;
            timeout_d   = 1'b1;
            err_set     = 1'b1;
          end else begin
            wait_d = wait_q - 4'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A new error in the same cycle as a clear request must stay visible.
    err_d = err_set ? 1'b1 : (host.in_err_clr ? 1'b0 : err_q);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      load_value_q <= 8'd0;
      load_now_q   <= 1'b0;
      write_now_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= 8'd0;
      timeout_q    <= 1'b0;
      err_q        <= 1'b0;
      hold_q       <= 4'd0;
      wait_q       <= 4'd0;
      left_q       <= 8'd0;
      have_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      load_value_q <= load_value_d;
      load_now_q   <= load_now_d;
      write_now_q  <= write_now_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      timeout_q    <= timeout_d;
      err_q        <= err_d;
      hold_q       <= hold_d;
      wait_q       <= wait_d;
      left_q       <= left_d;
      have_prev_q  <= have_prev_d;
    end
  end

  assign host.out_cmd_ready  = ready_q;
  assign host.out_load_value = load_value_q;
  assign host.out_load_now   = load_now_q;
  assign host.out_write_now  = write_now_q;
  assign host.out_rd_valid   = rd_valid_q;
  assign host.out_rd_data    = rd_data_q;
  assign host.out_timeout    = timeout_q;
  assign host.out_err        = err_q;

endmodule

// File: tb/tb_counter_host.sv
// Bench for counter_host: a free-running 8-bit counter model closes the loop
// (loads on load_now, otherwise increments every cycle, asserts ena one cycle
// after write_now); an override path lets the bench drive the bus directly.
module tb_counter_host;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_BURST = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;

  counter_host_if hif ();

  counter_host #(.LOAD_HOLD(2), .TIMEOUT(4)) dut (
    .in_clk (clk),
    .in_rst (rst),
    .host   (hif)
  );

  always #5 clk = ~clk;

  // Counter model and bus override.
  logic [7:0] cnt = 8'd0;
  logic [7:0] model_ena = 8'h00;
  logic       ovr = 1'b0;
  logic [7:0] ovr_value = 8'd0;
  logic [7:0] ovr_ena = 8'h00;

  always @(posedge clk) begin
    if (hif.out_load_now) cnt <= hif.out_load_value;
    else                  cnt <= cnt + 8'd1;
    model_ena <= hif.out_write_now ? 8'hFF : 8'h00;
  end

  assign hif.in_bus_value = ovr ? ovr_value : cnt;
  assign hif.in_bus_ena   = ovr ? ovr_ena   : model_ena;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] load_val;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t vecs [4];

  // Observation results filled by watch().
  logic [7:0] samp [16];
  int ns, first_i, last_i, nto, to_i;
  logic wr_at_last, rdy_after_to, err_at_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a command and return one step after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [7:0] data);
    int n;
    hif.in_cmd_valid = 1'b1;
    hif.in_cmd_op    = op;
    hif.in_cmd_data  = data;
    n = 0;
    while (!hif.out_cmd_ready && n < 50) begin
      cyc();
      n++;
    end
    chk("cmd_ready_wait", (n < 50), 1);
    cyc();
    hif.in_cmd_valid = 1'b0;
    hif.in_cmd_op    = OP_NOP;
  endtask

  task automatic watch(input int ncyc);
    ns = 0; first_i = -1; last_i = -1; nto = 0; to_i = -1;
    wr_at_last = 1'b1; rdy_after_to = 1'b0; err_at_to = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      if (to_i >= 0 && i == to_i + 1) rdy_after_to = hif.out_cmd_ready;
      if (hif.out_rd_valid) begin
        if (ns < 16) samp[ns] = hif.out_rd_data;
        ns++;
        if (first_i < 0) first_i = i;
        last_i = i;
        wr_at_last = hif.out_write_now;
      end
      if (hif.out_timeout) begin
        nto++;
        to_i = i;
        err_at_to = hif.out_err;
      end
      cyc();
    end
  endtask

  // LOAD and verify the strobe width; ends with ready high again.
  task automatic do_load(input logic [7:0] v);
    int hold;
    logic wr;
    send(OP_LOAD, v);
    chk("load_value", hif.out_load_value, v);
    hold = 0; wr = 1'b0;
    while (hif.out_load_now && hold < 20) begin
      if (hif.out_write_now) wr = 1'b1;
      hold++;
      cyc();
    end
    chk("load_hold_cycles", hold, 2);
    chk("load_write_now", wr, 0);
    chk("load_ready_back", hif.out_cmd_ready, 1);
    chk("load_value_kept", hif.out_load_value, v);
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_ready"}, hif.out_cmd_ready, 1);
    chk({tag, "_load_now"}, hif.out_load_now, 0);
    chk({tag, "_write_now"}, hif.out_write_now, 0);
    chk({tag, "_load_value"}, hif.out_load_value, 0);
    chk({tag, "_rd_valid"}, hif.out_rd_valid, 0);
    chk({tag, "_rd_data"}, hif.out_rd_data, 0);
    chk({tag, "_timeout"}, hif.out_timeout, 0);
    chk({tag, "_err"}, hif.out_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [7:0] bdat [3];
    logic [7:0] exp_b [5];

    hif.in_cmd_valid = 1'b0;
    hif.in_cmd_op    = OP_NOP;
    hif.in_cmd_data  = 8'd0;
    hif.in_err_clr   = 1'b0;

    // LOAD v, then immediate READ: capture happens two counts after the load.
    vecs[0] = '{8'h40, 8'h42};
    vecs[1] = '{8'h00, 8'h02};
    vecs[2] = '{8'hFE, 8'h00};
    vecs[3] = '{8'h7F, 8'h81};

    rst = 1'b1;
    cyc(); cyc();
    chk_idle_reset("reset");
    rst = 1'b0;
    cyc();

    // NOP is accepted and ready stays high.
    send(OP_NOP, 8'h00);
    chk("nop_ready", hif.out_cmd_ready, 1);

    for (int k = 0; k < 4; k++) begin
      do_load(vecs[k].load_val);
      send(OP_READ, 8'h00);
      chk("read_write_now_rise", hif.out_write_now, 1);
      chk("read_ready_drop", hif.out_cmd_ready, 0);
      watch(6);
      chk("read_nvalid", ns, 1);
      chk("read_latency", first_i, 2);
      chk("read_data", samp[0], vecs[k].exp_rd);
      chk("read_write_now_drop", wr_at_last, 0);
      chk("read_err", hif.out_err, 0);
      chk("read_timeout", nto, 0);
    end

    // Model burst across the FF->00 wrap: load FD, samples FF..03.
    exp_b[0] = 8'hFF; exp_b[1] = 8'h00; exp_b[2] = 8'h01;
    exp_b[3] = 8'h02; exp_b[4] = 8'h03;
    do_load(8'hFD);
    send(OP_BURST, 8'd5);
    watch(10);
    chk("burst_nvalid", ns, 5);
    chk("burst_first", first_i, 2);
    chk("burst_consecutive", last_i - first_i, 4);
    for (int k = 0; k < 5; k++) chk("burst_data", samp[k], exp_b[k]);
    chk("burst_err", hif.out_err, 0);
    chk("burst_write_now_drop", wr_at_last, 0);
    chk("burst_write_now_after", hif.out_write_now, 0);

    // Bench-driven burst with a skipped value.
    bdat[0] = 8'h10; bdat[1] = 8'h11; bdat[2] = 8'h13;
    ovr = 1'b1; ovr_ena = 8'hFF; ovr_value = 8'h00;
    send(OP_BURST, 8'd3);
    for (int k = 0; k < 3; k++) begin
      ovr_value = bdat[k];
      cyc();
      chk("mis_rd_valid", hif.out_rd_valid, 1);
      chk("mis_rd_data", hif.out_rd_data, bdat[k]);
      if (k < 2) chk("mis_err_before", hif.out_err, 0);
    end
    chk("mis_err_after", hif.out_err, 1);
    chk("mis_write_now_drop", hif.out_write_now, 0);
    cyc();
    chk("mis_no_extra_valid", hif.out_rd_valid, 0);
    chk("mis_err_sticky", hif.out_err, 1);
    hif.in_err_clr = 1'b1;
    cyc();
    hif.in_err_clr = 1'b0;
    chk("err_clr", hif.out_err, 0);

    // READ timeout with enable stuck low; err_clr held to show set wins.
    ovr_ena = 8'h00;
    hif.in_err_clr = 1'b1;
    send(OP_READ, 8'h00);
    chk("to_write_now_rise", hif.out_write_now, 1);
    watch(7);
    hif.in_err_clr = 1'b0;
    chk("to_npulse", nto, 1);
    chk("to_latency", to_i, 4);
    chk("to_err_set_wins", err_at_to, 1);
    chk("to_no_valid", ns, 0);
    chk("to_ready_next", rdy_after_to, 1);
    chk("to_write_now_low", hif.out_write_now, 0);

    // Timeout without a concurrent clear leaves err set.
    send(OP_READ, 8'h00);
    watch(6);
    chk("to2_npulse", nto, 1);
    chk("to2_err", hif.out_err, 1);
    hif.in_err_clr = 1'b1;
    cyc();
    hif.in_err_clr = 1'b0;
    chk("to2_err_clr", hif.out_err, 0);

    // Partial enable for one cycle, then full enable.
    send(OP_READ, 8'h00);
    ovr_ena = 8'h0F; ovr_value = 8'h55;
    cyc();
    chk("part_err", hif.out_err, 1);
    chk("part_no_valid", hif.out_rd_valid, 0);
    ovr_ena = 8'hFF; ovr_value = 8'hA7;
    cyc();
    chk("part_rd_valid", hif.out_rd_valid, 1);
    chk("part_rd_data", hif.out_rd_data, 8'hA7);
    chk("part_write_now_drop", hif.out_write_now, 0);
    chk("part_err_sticky", hif.out_err, 1);
    ovr = 1'b0; ovr_ena = 8'h00;
    cyc();

    // Reset during the first LOAD cycle.
    send(OP_LOAD, 8'h33);
    chk("rl_load_now", hif.out_load_now, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_idle_reset("rst_load");
    cyc();

    // Reset in the middle of a burst.
    send(OP_BURST, 8'd10);
    cyc(); cyc(); cyc();
    chk("rb_in_burst", hif.out_rd_valid, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_idle_reset("rst_burst");
    cyc();
    chk("rb_still_idle", hif.out_write_now, 0);

    do_load(8'h20);
    send(OP_READ, 8'h00);
    watch(6);
    chk("post_rst_read", samp[0], 8'h22);
    chk("post_rst_nvalid", ns, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
